// File: rtl/mult_defs_pkg.sv
// Shared constants for the MULT/MULTU sequencer: operand width default,
// iteration count and the 3-bit state encodings.
package mult_defs;

  localparam int DEF_WIDTH  = 32;
  localparam int ITER_COUNT = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NEGA  = 3'd1;
  localparam logic [2:0] S_NEGB  = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_FIXLO = 3'd4;
  localparam logic [2:0] S_FIXHI = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    NEGA  = S_NEGA,
    NEGB  = S_NEGB,
    ITER  = S_ITER,
    FIXLO = S_FIXLO,
    FIXHI = S_FIXHI,
    DONE  = S_DONE
  } mult_state_e;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Shift-add 32x32->64 multiply sequencer driving one external combinational
// adder per cycle; the same adder performs the sign negations for MULT.
module mult_seq_ctrl
  import mult_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_in1,
  output logic [WIDTH-1:0] add_in2,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mult_state_e      state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             cfix_q, cfix_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cfix_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cfix_q  <= cfix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cfix_d  = cfix_q;
    add_in1 = '0;
    add_in2 = '0;
    add_cin = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          mcand_d = op_a;
          lo_d    = op_b;
          hi_d    = '0;
          cnt_d   = '0;
          sa_d    = is_signed & op_a[WIDTH-1];
          sb_d    = is_signed & op_b[WIDTH-1];
          neg_d   = sa_d ^ sb_d;
          if (sa_d)      state_d = NEGA;
          else if (sb_d) state_d = NEGB;
          else           state_d = ITER;
        end
      end
      NEGA: begin
        add_in1 = ~mcand_q;
        add_cin = 1'b1;
        mcand_d = add_sum;
        state_d = sb_q ? NEGB : ITER;
      end
      NEGB: begin
        add_in1 = ~lo_q;
        add_cin = 1'b1;
        lo_d    = add_sum;
        state_d = ITER;
      end
      ITER: begin
        // Carry-out becomes the new MSB as the product shifts right one bit.
        add_in1        = hi_q;
        add_in2        = lo_q[0] ? mcand_q : '0;
        {hi_d, lo_d}   = {add_cout, add_sum, lo_q[WIDTH-1:1]};
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER_COUNT - 1))
          state_d = neg_q ? FIXLO : DONE;
      end
      FIXLO: begin
        add_in1 = ~lo_q;
        add_cin = 1'b1;
        lo_d    = add_sum;
        cfix_d  = add_cout;
        state_d = FIXHI;
      end
      FIXHI: begin
        add_in1 = ~hi_q;
        add_cin = cfix_q;
        hi_d    = add_sum;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl with a behavioural ripple adder and a scoreboard
// of expected products and latencies.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] add_in1, add_in2, add_sum;
  logic        add_cin, add_cout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2} + {32'b0, add_cin};

  mult_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic signed [63:0] xa, xb;
    logic [63:0] p;
    logic na, nb;
    xa = {{32{a[31]}}, a};
    xb = {{32{b[31]}}, b};
    p  = s ? 64'(xa * xb) : ({32'b0, a} * {32'b0, b});
    na = s & a[31];
    nb = s & b[31];
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.lat = 33 + int'(na) + int'(nb) + ((na ^ nb) ? 2 : 0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int inj_cyc,
                        output logic [31:0] ohi, output logic [31:0] olo,
                        output int lat, output int busy_cnt,
                        output logic tail_ok, output logic timed_out);
    int cyc;
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_cnt = 0; timed_out = 1'b0;
    while (1) begin
      if (busy) busy_cnt++;
      if (cyc == inj_cyc) begin
        start = 1'b1; op_a = 32'h1234_5678; op_b = 32'h0000_0009; is_signed = ~s;
      end else if (cyc == inj_cyc + 1) begin
        start = 1'b0;
      end
      if (done) break;
      if (cyc >= 100) begin timed_out = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    lat = cyc; ohi = hi; olo = lo;
    @(negedge clk);
    tail_ok = (done == 1'b0) && (busy == 1'b0);
  endtask

  task automatic test_reset;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h want=0", {hi, lo}); end
    total++; if ({add_in1, add_in2, add_cin} !== 65'h0) begin bad++; $display("FAIL reset_adder got=%h/%h/%b want=0", add_in1, add_in2, add_cin); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_table(input string tag, input logic [31:0] ta[], input logic [31:0] tb[], input logic s);
    logic [31:0] ohi, olo; int lat, bc; logic tok, to; exp_t e;
    for (int i = 0; i < ta.size(); i++) begin
      sbq.push_back(model(ta[i], tb[i], s));
      run_op(ta[i], tb[i], s, -5, ohi, olo, lat, bc, tok, to);
      e = sbq.pop_front();
      total++; if (to) begin bad++; $display("FAIL %s[%0d]_timeout got=no done want=done", tag, i); end
      total++; if ({ohi, olo} !== {e.hi, e.lo}) begin bad++; $display("FAIL %s[%0d]_product got=%h_%h want=%h_%h", tag, i, ohi, olo, e.hi, e.lo); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL %s[%0d]_latency got=%0d want=%0d", tag, i, lat, e.lat); end
      total++; if (bc !== e.lat) begin bad++; $display("FAIL %s[%0d]_busy_cycles got=%0d want=%0d", tag, i, bc, e.lat); end
      total++; if (tok !== 1'b1) begin bad++; $display("FAIL %s[%0d]_tail got=done/busy high want=low", tag, i); end
    end
  endtask

  task automatic test_multu;
    logic [31:0] ta[] = '{32'd3, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
    logic [31:0] tb[] = '{32'd5, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000};
    run_table("multu", ta, tb, 1'b0);
    total++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL multu_hold got=%h want=4000000000000000", {hi, lo}); end
  endtask

  task automatic test_mult_signed;
    logic [31:0] ta[] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] tb[] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'hFFFF_FFFF};
    run_table("mult", ta, tb, 1'b1);
  endtask

  task automatic test_ignore_start;
    logic [31:0] ohi, olo; int lat, bc; logic tok, to; exp_t e;
    sbq.push_back(model(32'd1000, 32'd2000, 1'b0));
    run_op(32'd1000, 32'd2000, 1'b0, 10, ohi, olo, lat, bc, tok, to);
    e = sbq.pop_front();
    total++; if ({ohi, olo} !== {e.hi, e.lo}) begin bad++; $display("FAIL ignore_product got=%h_%h want=%h_%h", ohi, olo, e.hi, e.lo); end
    total++; if (lat !== e.lat || to) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, e.lat); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_restart got busy=%b want=0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ohi, olo; int lat, bc; logic tok, to; exp_t e;
    logic [31:0] a[2] = '{32'hFFFF_FFF0, 32'd12345};
    logic [31:0] b[2] = '{32'd16, 32'hFFFF_0000};
    logic        s[2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(model(a[i], b[i], s[i]));
      run_op(a[i], b[i], s[i], -5, ohi, olo, lat, bc, tok, to);
      e = sbq.pop_front();
      total++; if ({ohi, olo} !== {e.hi, e.lo}) begin bad++; $display("FAIL b2b[%0d]_product got=%h_%h want=%h_%h", i, ohi, olo, e.hi, e.lo); end
      total++; if (lat !== e.lat || to) begin bad++; $display("FAIL b2b[%0d]_latency got=%0d want=%0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_reset_midop;
    logic [31:0] ohi, olo; int lat, bc; logic tok, to; exp_t e;
    sbq.push_back(model(32'd100, 32'd200, 1'b0));
    op_a = 32'd100; op_b = 32'd200; is_signed = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midop_busy_before got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    sbq.delete();
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midop_ctrl got=%b%b want=00", busy, done); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL midop_hilo got=%h want=0", {hi, lo}); end
    total++; if ({add_in1, add_in2, add_cin} !== 65'h0) begin bad++; $display("FAIL midop_adder got=%h/%h/%b want=0", add_in1, add_in2, add_cin); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    sbq.push_back(model(32'd7, 32'd6, 1'b0));
    run_op(32'd7, 32'd6, 1'b0, -5, ohi, olo, lat, bc, tok, to);
    e = sbq.pop_front();
    total++; if ({ohi, olo} !== 64'd42) begin bad++; $display("FAIL after_reset_product got=%h_%h want=0_2a", ohi, olo); end
    total++; if (lat !== e.lat || to) begin bad++; $display("FAIL after_reset_latency got=%0d want=%0d", lat, e.lat); end
  endtask

  task automatic test_random;
    logic [31:0] ohi, olo, a, b; int lat, bc; logic tok, to, s; exp_t e;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      sbq.push_back(model(a, b, s));
      run_op(a, b, s, -5, ohi, olo, lat, bc, tok, to);
      e = sbq.pop_front();
      total++; if ({ohi, olo} !== {e.hi, e.lo}) begin bad++; $display("FAIL rand[%0d]_product a=%h b=%h s=%b got=%h_%h want=%h_%h", i, a, b, s, ohi, olo, e.hi, e.lo); end
      total++; if (lat !== e.lat || to) begin bad++; $display("FAIL rand[%0d]_latency got=%0d want=%0d", i, lat, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
